// File: rtl/cheb_trig_expander.sv
// Chebyshev angle-multiple expander: from cos(pi*x), sin(pi*x) emits
// cos(k*pi*x), sin(k*pi*x) for k = 1..ORDER, one term pair per clock.
module cheb_trig_expander #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 14,
    parameter int unsigned ORDER = 4,
    parameter int unsigned KW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cos1_in,
    input  logic [WIDTH-1:0] sin1_in,
    output logic             out_valid,
    output logic [KW-1:0]    out_k,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out,
    output logic             out_last
);

    // Product (2*WIDTH+1 bits) minus the previous term needs one more bit.
    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam logic signed [PW-1:0]    SAT_HI = PW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW-1:0]    SAT_LO = -SAT_HI - PW'(1);
    localparam logic signed [WIDTH-1:0] ONE    = WIDTH'(2 ** FRAC);
    localparam logic [KW-1:0]           K_LAST = KW'(ORDER);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_d;

    logic signed [WIDTH-1:0] c1_q, c1_d;
    logic signed [WIDTH-1:0] cos_prev, cos_prev_d, cos_cur, cos_cur_d;
    logic signed [WIDTH-1:0] sin_prev, sin_prev_d, sin_cur, sin_cur_d;
    logic signed [WIDTH-1:0] cos_next, sin_next;

    logic             in_ready_d, out_valid_d, out_last_d;
    logic [KW-1:0]    out_k_d;
    logic [WIDTH-1:0] cos_out_d, sin_out_d;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[WIDTH-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    // One recurrence step: sat(((2*c1*t_k) >>> FRAC) - t_{k-1}).
    function automatic logic signed [WIDTH-1:0] step(
        input logic signed [WIDTH-1:0] c1,
        input logic signed [WIDTH-1:0] cur,
        input logic signed [WIDTH-1:0] prev
    );
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] full;
        prod = PW'(c1) * PW'(cur);
        full = ((prod <<< 1) >>> FRAC) - PW'(prev);
        return sat(full);
    endfunction

    always_comb begin
        cos_next = step(c1_q, cos_cur, cos_prev);
        sin_next = step(c1_q, sin_cur, sin_prev);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        c1_d        = c1_q;
        cos_prev_d  = cos_prev;
        cos_cur_d   = cos_cur;
        sin_prev_d  = sin_prev;
        sin_cur_d   = sin_cur;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_k_d     = out_k;
        cos_out_d   = cos_out;
        sin_out_d   = sin_out;

        case (state)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (in_valid) begin
                    state_d     = RUN;
                    c1_d        = cos1_in;
                    cos_prev_d  = ONE;
                    cos_cur_d   = cos1_in;
                    sin_prev_d  = '0;
                    sin_cur_d   = sin1_in;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_k_d     = KW'(1);
                    cos_out_d   = cos1_in;
                    sin_out_d   = sin1_in;
                end
            end
            RUN: begin
                if (out_k == K_LAST) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    out_k_d    = out_k + KW'(1);
                    out_last_d = (out_k_d == K_LAST);
                    cos_out_d  = cos_next;
                    sin_out_d  = sin_next;
                    cos_prev_d = cos_cur;
                    cos_cur_d  = cos_next;
                    sin_prev_d = sin_cur;
                    sin_cur_d  = sin_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            c1_q      <= '0;
            cos_prev  <= '0;
            cos_cur   <= '0;
            sin_prev  <= '0;
            sin_cur   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_k     <= '0;
            cos_out   <= '0;
            sin_out   <= '0;
        end else begin
            state     <= state_d;
            c1_q      <= c1_d;
            cos_prev  <= cos_prev_d;
            cos_cur   <= cos_cur_d;
            sin_prev  <= sin_prev_d;
            sin_cur   <= sin_cur_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_k     <= out_k_d;
            cos_out   <= cos_out_d;
            sin_out   <= sin_out_d;
        end
    end

endmodule

// File: tb/tb_cheb_trig_expander.sv
// Randomized bench for cheb_trig_expander against a plain-arithmetic
// Chebyshev model; directed cases use known trig values.
module tb_cheb_trig_expander;

    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int ORDER = 4;
    localparam int KW    = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] cos1_in, sin1_in;
    logic                    out_valid;
    logic [KW-1:0]           out_k;
    logic signed [WIDTH-1:0] cos_out, sin_out;
    logic                    out_last;

    int total = 0;
    int bad   = 0;
    int exp_c[0:ORDER];
    int exp_s[0:ORDER];

    cheb_trig_expander #(.WIDTH(WIDTH), .FRAC(FRAC), .ORDER(ORDER), .KW(KW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cos1_in(cos1_in), .sin1_in(sin1_in), .out_valid(out_valid), .out_k(out_k),
        .cos_out(cos_out), .sin_out(sin_out), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Expected term list T_1..T_ORDER for cosine and sine sequences.
    task automatic compute_terms(input int c1, input int s1);
        longint t[0:ORDER];
        longint u[0:ORDER];
        t[0] = 16384; t[1] = c1;
        u[0] = 0;     u[1] = s1;
        for (int k = 2; k <= ORDER; k++) begin
            t[k] = clamp(floor_div(2 * longint'(c1) * t[k-1], 16384) - t[k-2]);
            u[k] = clamp(floor_div(2 * longint'(c1) * u[k-1], 16384) - u[k-2]);
        end
        for (int k = 0; k <= ORDER; k++) begin
            exp_c[k] = int'(t[k]);
            exp_s[k] = int'(u[k]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; cos1_in = '0; sin1_in = '0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_k !== '0 || cos_out !== '0 ||
            sin_out !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b k=%0d cos=%0d sin=%0d last=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_k, cos_out, sin_out, out_last);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed;
        int dc[4] = '{16384, 0, 8192, 32767};
        int ds[4] = '{0, 16384, 14189, 0};
        int tab_c[3][4] = '{'{16384, 16384, 16384, 16384},
                            '{0, -16384, 0, 16384},
                            '{8192, -8192, -16384, -8192}};
        int tab_s[3][4] = '{'{0, 0, 0, 0},
                            '{16384, 0, -16384, 0},
                            '{14189, 14189, 0, -14189}};
        for (int i = 0; i < 4; i++) begin
            compute_terms(dc[i], ds[i]);
            if (i < 3) begin
                for (int k = 1; k <= ORDER; k++) begin
                    exp_c[k] = tab_c[i][k-1];
                    exp_s[k] = tab_s[i][k-1];
                end
            end
            @(negedge clk);
            in_valid = 1'b1; cos1_in = WIDTH'(dc[i]); sin1_in = WIDTH'(ds[i]);
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 1; k <= ORDER; k++) begin
                if (k > 1) @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || int'(out_k) !== k || int'(cos_out) !== exp_c[k] ||
                    int'(sin_out) !== exp_s[k] || out_last !== (k == ORDER) || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL directed%0d k=%0d: vld=%b k=%0d cos=%0d sin=%0d last=%b rdy=%b, want cos=%0d sin=%0d",
                             i, k, out_valid, out_k, cos_out, sin_out, out_last, in_ready, exp_c[k], exp_s[k]);
                end
                if (i == 3 && k == 2) begin
                    total++;
                    if (int'(cos_out) !== 32767) begin
                        bad++;
                        $display("FAIL saturation: cos=%0d, want 32767", cos_out);
                    end
                end
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 ||
                int'(cos_out) !== exp_c[ORDER] || int'(sin_out) !== exp_s[ORDER]) begin
                bad++;
                $display("FAIL directed%0d end: vld=%b last=%b rdy=%b cos=%0d sin=%0d, want 0 0 1 %0d %0d",
                         i, out_valid, out_last, in_ready, cos_out, sin_out, exp_c[ORDER], exp_s[ORDER]);
            end
        end
    endtask

    task automatic test_random;
        int c1, s1;
        for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) begin
                c1 = int'($urandom_range(32768)) - 16384;
                s1 = int'($urandom_range(32768)) - 16384;
            end else begin
                c1 = int'($urandom_range(65535)) - 32768;
                s1 = int'($urandom_range(65535)) - 32768;
            end
            compute_terms(c1, s1);
            @(negedge clk);
            in_valid = 1'b1; cos1_in = WIDTH'(c1); sin1_in = WIDTH'(s1);
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 1; k <= ORDER; k++) begin
                if (k > 1) @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || int'(out_k) !== k || int'(cos_out) !== exp_c[k] ||
                    int'(sin_out) !== exp_s[k] || out_last !== (k == ORDER)) begin
                    bad++;
                    $display("FAIL random c1=%0d s1=%0d k=%0d: vld=%b k=%0d cos=%0d sin=%0d last=%b, want cos=%0d sin=%0d",
                             c1, s1, k, out_valid, out_k, cos_out, sin_out, out_last, exp_c[k], exp_s[k]);
                end
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL random end: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        int a_c, a_s, b_c, b_s;
        a_c = int'($urandom_range(32768)) - 16384; a_s = int'($urandom_range(32768)) - 16384;
        b_c = int'($urandom_range(32768)) - 16384; b_s = int'($urandom_range(32768)) - 16384;
        compute_terms(a_c, a_s);
        @(negedge clk);
        in_valid = 1'b1; cos1_in = WIDTH'(a_c); sin1_in = WIDTH'(a_s);
        for (int k = 1; k <= ORDER; k++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || int'(out_k) !== k ||
                int'(cos_out) !== exp_c[k] || int'(sin_out) !== exp_s[k]) begin
                bad++;
                $display("FAIL b2b_A k=%0d: rdy=%b vld=%b k=%0d cos=%0d sin=%0d, want rdy=0 cos=%0d sin=%0d",
                         k, in_ready, out_valid, out_k, cos_out, sin_out, exp_c[k], exp_s[k]);
            end
            if (k < ORDER) begin
                cos1_in = WIDTH'($urandom); sin1_in = WIDTH'($urandom);
            end else begin
                cos1_in = WIDTH'(b_c); sin1_in = WIDTH'(b_s);
            end
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        compute_terms(b_c, b_s);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= ORDER; k++) begin
            if (k > 1) @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || int'(out_k) !== k || int'(cos_out) !== exp_c[k] ||
                int'(sin_out) !== exp_s[k] || out_last !== (k == ORDER)) begin
                bad++;
                $display("FAIL b2b_B k=%0d: vld=%b k=%0d cos=%0d sin=%0d last=%b, want cos=%0d sin=%0d",
                         k, out_valid, out_k, cos_out, sin_out, out_last, exp_c[k], exp_s[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int c1, s1;
        c1 = int'($urandom_range(32768)) - 16384; s1 = int'($urandom_range(32768)) - 16384;
        @(negedge clk);
        in_valid = 1'b1; cos1_in = WIDTH'(c1); sin1_in = WIDTH'(s1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || int'(out_k) !== 2) begin
            bad++;
            $display("FAIL midrun_k2: vld=%b k=%0d, want 1 2", out_valid, out_k);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_k !== '0 || cos_out !== '0 ||
            sin_out !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: rdy=%b vld=%b k=%0d cos=%0d sin=%0d last=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_k, cos_out, sin_out, out_last);
        end
        repeat (2) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL midrun_quiet: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
            end
        end
        c1 = int'($urandom_range(32768)) - 16384; s1 = int'($urandom_range(32768)) - 16384;
        compute_terms(c1, s1);
        in_valid = 1'b1; cos1_in = WIDTH'(c1); sin1_in = WIDTH'(s1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= ORDER; k++) begin
            if (k > 1) @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || int'(out_k) !== k || int'(cos_out) !== exp_c[k] ||
                int'(sin_out) !== exp_s[k] || out_last !== (k == ORDER)) begin
                bad++;
                $display("FAIL post_reset k=%0d: vld=%b k=%0d cos=%0d sin=%0d last=%b, want cos=%0d sin=%0d",
                         k, out_valid, out_k, cos_out, sin_out, out_last, exp_c[k], exp_s[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cheb_trig_expander.md
Name: cheb_trig_expander

Overview:
Trigonometric functional-expansion stage of the FLAF front end. Takes one sample's base pair cos(pi*x) and sin(pi*x), produced by the upstream cosine/sine LUT. It then generates cos(k*pi*x) and sin(k*pi*x) for k = 1..ORDER, one term pair per clock, using the Chebyshev angle-multiple recurrence. The term stream feeds the downstream DelayUnit pipeline and the weight-update datapath.

Parameters:
WIDTH, 16, signed two's-complement width of all data ports.
FRAC, 14, fractional bits; 1.0 = 2^FRAC = 16384.
ORDER, 4, number of angle multiples generated per sample (>= 2).
KW, 3, width of the term index output; must satisfy 2^KW > ORDER.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  base pair valid.
in_ready  output  1  block can accept a base pair.
cos1_in  input  WIDTH  cos(pi*x), signed QFRAC.
sin1_in  input  WIDTH  sin(pi*x), signed QFRAC.
out_valid  output  1  term pair valid this cycle.
out_k  output  KW  term index k (1..ORDER).
cos_out  output  WIDTH  cos(k*pi*x).
sin_out  output  WIDTH  sin(k*pi*x).
out_last  output  1  high with the k = ORDER term.

Behaviour:
- Single clock domain, clk. Synchronous active-high reset. All outputs are registered.
- Reset values: in_ready=1, out_valid=0, out_k=0, cos_out=0, sin_out=0, out_last=0. State = IDLE and all internal registers are cleared.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
- Accept: on a rising edge with state=IDLE and in_valid=1, latch c1=cos1_in and s1=sin1_in, then go to RUN.
  - On that same edge, drive out_valid=1, out_k=1, cos_out=c1, sin_out=s1.
  - Latency is 1 cycle from accept to term k=1. Term k appears k cycles after the accept edge.
- Recurrence, one step per cycle in RUN:
  - cos_{k+1} = sat((2*c1*cos_k) >>> FRAC - cos_{k-1})
  - sin_{k+1} = sat((2*c1*sin_k) >>> FRAC - sin_{k-1})
  - Seeds: cos_0 = 2^FRAC, sin_0 = 0.
- Arithmetic rules:
  - Compute the product at full 2*WIDTH+1 bits.
  - Shift is arithmetic, truncating toward -inf; no rounding.
  - Subtract at full width.
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The saturated value is fed back into the recurrence.
- Term emission: the cycle with out_k = ORDER asserts out_last=1. On the following edge, state goes to IDLE, out_valid=0 and out_last=0. Data outputs hold their last values.
- Throughput: one sample every ORDER+1 cycles. in_valid held high is accepted on the first IDLE cycle.
- in_valid while in RUN is ignored. Nothing is latched and no error is raised. Upstream must hold the pair until in_ready=1.
- No output backpressure: the downstream stage always consumes.
- Reset mid-RUN aborts the sequence immediately. All outputs return to reset values on the next edge, and no further terms are emitted.
- out_valid is never asserted in IDLE except on the accept edge.

Test Plan:
- theta=0: cos1=16384, sin1=0 -> 4 terms with cos=16384 and sin=0; out_k=1,2,3,4; out_last only on k=4.
- theta=pi/2: cos1=0, sin1=16384 -> cos = 0, -16384, 0, 16384; sin = 16384, 0, -16384, 0.
- theta=pi/3: cos1=8192, sin1=14189 -> cos = 8192, -8192, -16384, -8192; sin = 14189, 14189, 0, -14189 (exact match).
- Saturation: cos1=32767, sin1=0 -> term k=2 cos = 32767 (clamped from 114680); no wrap to negative values.
- Handshake: in_valid held high with pairs A then B -> in_ready low for 4 cycles; B is accepted on the 5th cycle after A's accept; pairs presented while busy are ignored.
- Reset at k=2 of a run -> next cycle out_valid=0, all data outputs 0, in_ready=1; a new sample then runs cleanly from k=1.
